// File: rtl/ann_result_uart_tx.sv
// UART (8N1, LSB first) transmitter for the detector's output-layer values.
// Sends an 8-byte packet: header 0xA5, high/low byte of each value, checksum.
module ann_result_uart_tx #(
    parameter int CLKS_PER_BIT = 434,
    parameter int DATA_W       = 10,
    parameter int N_OUT        = 3
) (
    input  logic                    Clock,
    input  logic                    Rst,
    input  logic                    start,
    input  logic [N_OUT*DATA_W-1:0] out_ann,
    output logic                    busy,
    output logic                    done,
    output logic                    tx,
    output logic [2:0]              byte_idx
);

    localparam logic [1:0]  S_IDLE    = 2'd0;
    localparam logic [1:0]  S_START   = 2'd1;
    localparam logic [1:0]  S_DATA    = 2'd2;
    localparam logic [1:0]  S_STOP    = 2'd3;
    localparam logic [7:0]  HEADER    = 8'hA5;
    localparam logic [2:0]  LAST_IDX  = 3'(2*N_OUT+1);
    localparam logic [15:0] BAUD_LAST = 16'(CLKS_PER_BIT-1);

    function automatic logic [7:0] hi_byte(input logic [DATA_W-1:0] v);
        logic [15:0] e;
        e = 16'(v);
        return e[15:8];
    endfunction

    function automatic logic [7:0] lo_byte(input logic [DATA_W-1:0] v);
        logic [15:0] e;
        e = 16'(v);
        return e[7:0];
    endfunction

    // Header is not part of the sum; carries out of bit 7 are dropped.
    function automatic logic [7:0] calc_checksum(input logic [N_OUT*DATA_W-1:0] v);
        logic [7:0] s;
        s = 8'd0;
        for (int i = 0; i < N_OUT; i++) begin
            s = s + hi_byte(v[i*DATA_W +: DATA_W]) + lo_byte(v[i*DATA_W +: DATA_W]);
        end
        return s;
    endfunction

    logic [1:0]              state;
    logic [15:0]             baud_cnt;
    logic [2:0]              bit_cnt;
    logic [7:0]              shift;
    logic [N_OUT*DATA_W-1:0] vals;
    logic [7:0]              csum;
    logic [7:0]              cur_byte;
    logic [DATA_W-1:0]       sel_val;
    logic [2:0]              val_idx;
    logic                    bit_end;

    // Select the byte for the current packet position from the latched values.
    always_comb begin
        bit_end = (baud_cnt == BAUD_LAST);
        val_idx = (byte_idx - 3'd1) >> 1;
        sel_val = '0;
        for (int i = 0; i < N_OUT; i++) begin
            sel_val = (val_idx == 3'(i)) ? vals[i*DATA_W +: DATA_W] : sel_val;
        end
        if (byte_idx == 3'd0) begin
            cur_byte = HEADER;
        end else if (byte_idx == LAST_IDX) begin
            cur_byte = csum;
        end else begin
            cur_byte = byte_idx[0] ? hi_byte(sel_val) : lo_byte(sel_val);
        end
    end

    // Packet sequencer; tx only changes on bit boundaries.
    always_ff @(posedge Clock) begin
        if (Rst) begin
            state    <= S_IDLE;
            tx       <= 1'b1;
            busy     <= 1'b0;
            done     <= 1'b0;
            byte_idx <= 3'd0;
            baud_cnt <= 16'd0;
            bit_cnt  <= 3'd0;
            shift    <= 8'd0;
            vals     <= '0;
            csum     <= 8'd0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    tx       <= 1'b1;
                    busy     <= 1'b0;
                    baud_cnt <= 16'd0;
                    bit_cnt  <= 3'd0;
                    if (start) begin
                        vals     <= out_ann;
                        csum     <= calc_checksum(out_ann);
                        byte_idx <= 3'd0;
                        tx       <= 1'b0;
                        busy     <= 1'b1;
                        state    <= S_START;
                    end
                end
                S_START: begin
                    if (bit_end) begin
                        baud_cnt <= 16'd0;
                        bit_cnt  <= 3'd0;
                        tx       <= cur_byte[0];
                        shift    <= {1'b0, cur_byte[7:1]};
                        state    <= S_DATA;
                    end else begin
                        baud_cnt <= baud_cnt + 16'd1;
                    end
                end
                S_DATA: begin
                    if (bit_end) begin
                        baud_cnt <= 16'd0;
                        if (bit_cnt == 3'd7) begin
                            tx    <= 1'b1;
                            state <= S_STOP;
                        end else begin
                            tx      <= shift[0];
                            shift   <= {1'b0, shift[7:1]};
                            bit_cnt <= bit_cnt + 3'd1;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 16'd1;
                    end
                end
                S_STOP: begin
                    if (bit_end) begin
                        baud_cnt <= 16'd0;
                        if (byte_idx == LAST_IDX) begin
                            tx    <= 1'b1;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            state <= S_IDLE;
                        end else begin
                            byte_idx <= byte_idx + 3'd1;
                            tx       <= 1'b0;
                            state    <= S_START;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 16'd1;
                    end
                end
                default: begin
                    tx    <= 1'b1;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ann_result_uart_tx.sv
// Scoreboard bench: the driver queues expected bytes and done times, and
// a line monitor decodes tx frames and compares them as they complete.
module tb_ann_result_uart_tx;

    localparam int CPB = 4;
    localparam int DW  = 10;
    localparam int NO  = 3;
    localparam int PKT_CYCLES = 80 * CPB;

    logic          Clock = 1'b0;
    logic          Rst   = 1'b1;
    logic          start = 1'b0;
    logic [NO*DW-1:0] out_ann = '0;
    logic          busy;
    logic          done;
    logic          tx;
    logic [2:0]    byte_idx;

    ann_result_uart_tx #(.CLKS_PER_BIT(CPB), .DATA_W(DW), .N_OUT(NO)) dut (
        .Clock(Clock), .Rst(Rst), .start(start), .out_ann(out_ann),
        .busy(busy), .done(done), .tx(tx), .byte_idx(byte_idx)
    );

    always #5 Clock = ~Clock;

    int cyc = 0;
    always @(posedge Clock) cyc <= cyc + 1;

    int checks = 0;
    int passes = 0;
    logic [7:0] exp_q[$];
    int         exp_done_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Line monitor: every bit must hold one value for CPB consecutive samples.
    bit         mon_active = 1'b0;
    int         mon_bit = 0;
    int         mon_sub = 0;
    logic       bit_v = 1'b1;
    bit         glitch = 1'b0;
    logic [9:0] frame = '0;
    logic [7:0] exp_b;

    always @(negedge Clock) begin
        if (Rst) begin
            mon_active = 1'b0;
        end else begin
            if (!mon_active && tx === 1'b0) begin
                mon_active = 1'b1;
                mon_bit    = 0;
                mon_sub    = 0;
                glitch     = 1'b0;
            end
            if (mon_active) begin
                if (mon_sub == 0) bit_v = tx;
                else if (tx !== bit_v) glitch = 1'b1;
                if (mon_sub == CPB - 1) begin
                    frame[mon_bit] = bit_v;
                    mon_sub = 0;
                    if (mon_bit == 9) begin
                        mon_active = 1'b0;
                        if (exp_q.size() == 0) begin
                            checks++;
                            $display("FAIL unexpected_byte: got %02h expected none (cycle %0d)", frame[8:1], cyc);
                        end else begin
                            exp_b = exp_q.pop_front();
                            check("frame{glitch,stop,start,data}",
                                  {21'd0, glitch, frame[9], frame[0], frame[8:1]},
                                  {21'd0, 1'b0, 1'b1, 1'b0, exp_b});
                        end
                    end else begin
                        mon_bit++;
                    end
                end else begin
                    mon_sub++;
                end
            end
            if (done === 1'b1) begin
                if (exp_done_q.size() == 0) begin
                    checks++;
                    $display("FAIL unexpected_done: got done at cycle %0d expected none", cyc);
                end else begin
                    check("done_cycle", cyc, exp_done_q.pop_front());
                end
            end
        end
    end

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge Clock);
        #1;
    endtask

    // Issue start now; returns one cycle later (first cycle of line activity).
    task automatic send(input logic [DW-1:0] v0, input logic [DW-1:0] v1,
                        input logic [DW-1:0] v2, input logic [63:0] bytes);
        out_ann = {v2, v1, v0};
        start   = 1'b1;
        exp_done_q.push_back(cyc + 1 + PKT_CYCLES);
        for (int i = 7; i >= 0; i--) exp_q.push_back(bytes[i*8 +: 8]);
        wait_cycles(1);
        start = 1'b0;
        check("busy_after_start", busy, 1);
        check("tx_start_bit", tx, 0);
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while (busy === 1'b1 && n < budget) begin
            wait_cycles(1);
            n++;
        end
        if (busy !== 1'b0) begin
            checks++;
            $display("FAIL idle_timeout: got busy=%0b expected 0 within %0d cycles", busy, budget);
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got no end of test expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        wait_cycles(3);
        Rst = 1'b0;
        wait_cycles(5);
        // Reset held three cycles while idle
        Rst = 1'b1;
        wait_cycles(3);
        check("rst_tx", tx, 1);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_byte_idx", byte_idx, 0);
        Rst = 1'b0;
        wait_cycles(4);

        // Packet A, with a mid-packet input change and an ignored start
        send(10'h3FF, 10'h000, 10'h155, 64'hA5_03_FF_00_00_01_55_58);
        wait_cycles(1);
        out_ann = 30'h0ABCDEF1;
        wait_cycles(98);
        start = 1'b1;
        wait_cycles(1);
        start = 1'b0;
        wait_cycles(219);
        check("busy_last_cycle", busy, 1);
        wait_cycles(1);
        check("busy_at_done", busy, 0);
        check("done_pulse", done, 1);
        wait_cycles(1);
        check("done_one_cycle", done, 0);
        wait_cycles(60);
        check("no_queued_start_busy", busy, 0);
        check("no_queued_start_tx", tx, 1);

        // Checksum wrap, then a back-to-back packet started in the done cycle
        send(10'h3FF, 10'h3FF, 10'h3FF, 64'hA5_03_FF_03_FF_03_FF_06);
        wait_idle(PKT_CYCLES + 20);
        check("done_b2b", done, 1);
        send(10'h001, 10'h2AB, 10'h0FE, 64'hA5_00_01_02_AB_00_FE_AC);
        wait_idle(PKT_CYCLES + 20);
        wait_cycles(10);

        // Reset at cycle 150 aborts the packet without done
        send(10'h123, 10'h045, 10'h200, 64'hA5_01_23_00_45_02_00_6B);
        wait_cycles(149);
        Rst = 1'b1;
        exp_q.delete();
        exp_done_q.delete();
        wait_cycles(1);
        check("abort_tx", tx, 1);
        check("abort_busy", busy, 0);
        check("abort_byte_idx", byte_idx, 0);
        Rst = 1'b0;
        wait_cycles(PKT_CYCLES);
        check("abort_idle_busy", busy, 0);

        send(10'h123, 10'h045, 10'h200, 64'hA5_01_23_00_45_02_00_6B);
        wait_idle(PKT_CYCLES + 20);
        wait_cycles(5);
        check("bytes_outstanding", exp_q.size(), 0);
        check("done_outstanding", exp_done_q.size(), 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/ann_result_uart_tx.md
Name: ann_result_uart_tx

Overview:
- Transmitter for DrowsinessDetector1 classification results. Takes the three 10-bit output-layer values (out_ann) and sends them off-board as one framed packet over a UART line (8N1, LSB first).
- Sits beside the detector in the top level. Start is driven by the detector's done pulse or a key; tx drives a GPIO/UART pin.
- Data flows outward, opposite to the in1 feature path into the detector.

Parameters:
- CLKS_PER_BIT, 434, Clock cycles per UART bit (50 MHz / 115200). Legal range 2..65535.
- DATA_W, 10, width of each ANN output value. Fixed at 10; values up to 16 are legal.
- N_OUT, 3, number of ANN output values per packet.

Ports:
- Clock  in  1  system clock (CLOCK_50)
- Rst  in  1  synchronous, active-high reset
- start  in  1  request to send one packet; sampled on rising edge
- out_ann  in  N_OUT*DATA_W  flattened results; value i occupies [DATA_W*i+DATA_W-1 : DATA_W*i]
- busy  out  1  high while a packet is in flight
- done  out  1  one-cycle pulse when the last stop bit completes
- tx  out  1  UART serial line, idle high
- byte_idx  out  3  index of the byte currently being sent (0..7); debug/LED use

Behaviour:
- Reset (Rst=1 at an edge): state=IDLE, tx=1, busy=0, done=0, byte_idx=0, baud counter=0, bit counter=0.
- Reset mid-packet aborts the packet. tx returns to 1 on the next edge. No done pulse is produced.
- Packet format, 8 bytes, sent in order:
  - B0 = 0xA5 (header)
  - B1,B2 = value0 high byte then low byte
  - B3,B4 = value1 high byte then low byte
  - B5,B6 = value2 high byte then low byte
  - B7 = checksum
- High byte = {zero-pad, v[DATA_W-1:8]}. Low byte = v[7:0].
- Checksum = (B1+...+B6) mod 256. The header is excluded.
- State machine: IDLE -> START -> DATA -> STOP -> (START for next byte | IDLE).
- IDLE:
  - tx=1, busy=0.
  - start=1 at edge k: latch all of out_ann into an internal register, compute checksum, byte_idx=0, go to START.
  - busy=1 from cycle k+1.
  - out_ann changes after edge k do not affect the packet.
- START: tx=0 for exactly CLKS_PER_BIT cycles, then go to DATA with bit counter=0.
- DATA: tx=current byte[bit], LSB first, each bit held CLKS_PER_BIT cycles. After bit 7, go to STOP.
- STOP: tx=1 for CLKS_PER_BIT cycles. Then:
  - byte_idx<7: increment byte_idx and go to START. No inter-byte gap.
  - byte_idx==7: go to IDLE, assert done for one cycle, deassert busy in the same cycle.
- Latency: with start sampled at edge 0, line activity spans cycles 1 .. 80*CLKS_PER_BIT. done=1 and busy=0 in cycle 80*CLKS_PER_BIT+1.
- start while busy=1 is ignored. It is not queued.
- start in the cycle where done=1 is accepted, since the block is IDLE. The next packet's start bit begins the following cycle.
- Baud counter counts 0..CLKS_PER_BIT-1 and wraps at each bit boundary. No fractional-rate correction.
- tx is registered (glitch-free) and changes only on bit boundaries.

Test Plan:
- Reset: hold Rst 3 cycles mid-idle -> tx=1, busy=0, done=0, byte_idx=0.
- Basic packet, CLKS_PER_BIT=4, values 0x3FF, 0x000, 0x155, start pulse at edge 0:
  - decoded bytes must be A5 03 FF 00 00 01 55 58
  - busy high in cycles 1..320
  - done high only in cycle 321
- Bit timing: every bit, including start and stop bits, is exactly 4 cycles wide. The first byte on the line is 0,1,0,1,0,0,1,0,1,1 (start, 0xA5 LSB first, stop).
- Start while busy, plus input change after latch:
  - pulse start at cycle 100 and change out_ann at cycle 2 -> packet unchanged, only one done.
  - start in the done cycle -> second packet begins next cycle, back-to-back.
- Reset mid-packet: assert Rst at cycle 150 -> tx=1 and busy=0 next cycle, no done. A new start afterwards yields a full correct packet.
- Checksum wrap: values 0x3FF, 0x3FF, 0x3FF -> bytes A5 03 FF 03 FF 03 FF 06, since (3*0x102) mod 256 = 0x06.
